// File: rtl/audio_stream_pairer_if.sv
// Bundles the audio_stream_pairer ADC, core, DAC and status signals; slave = pairer side, master = environment side.
// desync_count exists only when DESYNC_CNT_EN is defined.
interface audio_stream_pairer_if #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_W-1:0]             adc_l_data;
    logic                          adc_l_valid;
    logic                          adc_l_ready;
    logic [DATA_W-1:0]             adc_r_data;
    logic                          adc_r_valid;
    logic                          adc_r_ready;
    logic [2*DATA_W-1:0]           core_in_data;
    logic                          core_in_valid;
    logic                          core_in_ready;
    logic [2*DATA_W-1:0]           core_out_data;
    logic                          core_out_valid;
    logic                          core_out_ready;
    logic [DATA_W-1:0]             dac_l_data;
    logic                          dac_l_valid;
    logic                          dac_l_ready;
    logic [DATA_W-1:0]             dac_r_data;
    logic                          dac_r_valid;
    logic                          dac_r_ready;
    logic                          desync;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
`ifdef DESYNC_CNT_EN
    logic [15:0]                   desync_count;
`endif

    modport slave (
        input  adc_l_data, adc_l_valid, adc_r_data, adc_r_valid,
        output adc_l_ready, adc_r_ready,
        output core_in_data, core_in_valid,
        input  core_in_ready,
        input  core_out_data, core_out_valid,
        output core_out_ready,
        output dac_l_data, dac_l_valid, dac_r_data, dac_r_valid,
        input  dac_l_ready, dac_r_ready,
        output desync, fifo_level
`ifdef DESYNC_CNT_EN
        , output desync_count
`endif
    );

    modport master (
        output adc_l_data, adc_l_valid, adc_r_data, adc_r_valid,
        input  adc_l_ready, adc_r_ready,
        input  core_in_data, core_in_valid,
        output core_in_ready,
        output core_out_data, core_out_valid,
        input  core_out_ready,
        input  dac_l_data, dac_l_valid, dac_r_data, dac_r_valid,
        output dac_l_ready, dac_r_ready,
        input  desync, fifo_level
`ifdef DESYNC_CNT_EN
        , input desync_count
`endif
    );
endinterface

// File: rtl/audio_stream_pairer.sv
// Pairs L/R ADC samples into stereo frames for the core and splits processed frames to L/R DAC streams; DESYNC_CNT_EN adds desync_count.
// Latency: frame valid the cycle after the second sample loads; FIFO head visible the cycle after push.
// Backpressure: holds stall (ready low) until the frame is taken; core_out_ready low when the FIFO is full.

module stream_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_rdy) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, rd_rdy})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rd_dat = mem[rd_ptr];
endmodule

module audio_stream_pairer #(
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int SKEW_MAX   = 64
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    audio_stream_pairer_if.slave   bus
);
    localparam int SW = $clog2(SKEW_MAX + 1);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } frame_t;

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              hold_l_full;
    logic              hold_r_full;
    logic [SW-1:0]     skew_cnt;
    logic              l_fire;
    logic              r_fire;
    logic              frame_fire;
    logic              lone;
    logic              skew_hit;

    assign bus.adc_l_ready   = !hold_l_full;
    assign bus.adc_r_ready   = !hold_r_full;
    assign l_fire            = bus.adc_l_valid & !hold_l_full;
    assign r_fire            = bus.adc_r_valid & !hold_r_full;
    assign bus.core_in_valid = hold_l_full & hold_r_full;
    assign bus.core_in_data  = {hold_l, hold_r};
    assign frame_fire        = hold_l_full & hold_r_full & bus.core_in_ready;
    assign lone              = hold_l_full ^ hold_r_full;
    assign skew_hit          = lone && (skew_cnt == SW'(SKEW_MAX));
    assign bus.desync        = skew_hit;

    // A load needs an empty hold, so it can never coincide with a clear of the same hold.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hold_l      <= '0;
            hold_r      <= '0;
            hold_l_full <= 1'b0;
            hold_r_full <= 1'b0;
            skew_cnt    <= '0;
        end else begin
            if (l_fire) begin
                hold_l      <= bus.adc_l_data;
                hold_l_full <= 1'b1;
            end else if (frame_fire || (skew_hit && hold_l_full)) begin
                hold_l_full <= 1'b0;
            end
            if (r_fire) begin
                hold_r      <= bus.adc_r_data;
                hold_r_full <= 1'b1;
            end else if (frame_fire || (skew_hit && hold_r_full)) begin
                hold_r_full <= 1'b0;
            end
            if (!lone || skew_hit) skew_cnt <= '0;
            else                   skew_cnt <= skew_cnt + 1'b1;
        end
    end

`ifdef DESYNC_CNT_EN
    logic [15:0] desync_count;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)                          desync_count <= '0;
        else if (skew_hit && desync_count != 16'hFFFF) desync_count <= desync_count + 1'b1;
    end
    assign bus.desync_count = desync_count;
`endif

    frame_t        head;
    logic [LW-1:0] level;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          l_done;
    logic          r_done;
    logic          l_vld;
    logic          r_vld;
    logic          l_hs;
    logic          r_hs;

    assign fifo_empty         = (level == '0);
    assign bus.core_out_ready = (level < LW'(FIFO_DEPTH));
    assign push               = bus.core_out_valid & (level < LW'(FIFO_DEPTH));
    assign l_vld              = !fifo_empty & !l_done;
    assign r_vld              = !fifo_empty & !r_done;
    assign l_hs               = l_vld & bus.dac_l_ready;
    assign r_hs               = r_vld & bus.dac_r_ready;
    assign pop                = !fifo_empty & (l_hs | l_done) & (r_hs | r_done);

    assign bus.dac_l_data  = head.l;
    assign bus.dac_r_data  = head.r;
    assign bus.dac_l_valid = l_vld;
    assign bus.dac_r_valid = r_vld;
    assign bus.fifo_level  = level;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            l_done <= 1'b0;
            r_done <= 1'b0;
        end else if (pop) begin
            l_done <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (l_hs) l_done <= 1'b1;
            if (r_hs) r_done <= 1'b1;
        end
    end

    stream_fifo #(
        .W     (2*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk    (clk_clk),
        .rst_n  (reset_reset_n),
        .wr_vld (push),
        .wr_dat (bus.core_out_data),
        .rd_rdy (pop),
        .rd_dat (head),
        .level  (level)
    );
endmodule

// File: doc/audio_stream_pairer.md
Name: audio_stream_pairer

Overview:
- Bridges the audio controller's per-channel Avalon-ST streams and the stereo reverb core.
- Input side: consumes the left/right ADC source streams (24-bit), pairs them into one 48-bit stereo frame and hands it to the core with valid/ready.
- Output side: buffers processed stereo frames in a small FIFO and splits each frame into the left/right DAC sink streams.
- Detects and recovers from channel desynchronisation.

Parameters:
- DATA_W, 24, sample width per channel.
- FIFO_DEPTH, 4, output FIFO entries; must be a power of 2 and at least 2.
- SKEW_MAX, 64, cycles one channel may sit held alone before resync.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset_n  in  1  asynchronous, active-low reset.
- adc_l_data  in  DATA_W  left sample from the controller's left-channel source.
- adc_l_valid  in  1  left sample valid.
- adc_l_ready  out  1  left sample accepted when high with valid.
- adc_r_data, adc_r_valid, adc_r_ready: same as left, for the right channel.
- core_in_data  out  2*DATA_W  stereo frame {L[47:24], R[23:0]} to the core.
- core_in_valid  out  1  frame valid.
- core_in_ready  in  1  core accepts frame.
- core_out_data  in  2*DATA_W  processed frame {L, R} from the core.
- core_out_valid  in  1  processed frame valid.
- core_out_ready  out  1  FIFO can accept a frame.
- dac_l_data  out  DATA_W  left sample to the controller's left-channel sink.
- dac_l_valid  out  1  left sample valid.
- dac_l_ready  in  1  sink accepts the left sample.
- dac_r_data, dac_r_valid, dac_r_ready: same as left, for the right channel.
- desync  out  1  one-cycle pulse on a resync event.
- fifo_level  out  clog2(FIFO_DEPTH)+1  output FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-low): holds empty, skew counter 0, FIFO empty.
  - Reset values: adc_l_ready=1, adc_r_ready=1, core_in_valid=0, core_in_data=0, core_out_ready=1, dac_l_valid=0, dac_r_valid=0, dac_*_data=0, desync=0, fifo_level=0.
  - Reset mid-operation discards all held and buffered data; no partial frame is emitted afterwards.
- Input holds: one holding register per channel with a full flag.
  - adc_x_ready = !hold_x_full.
  - The handshake (valid & ready) loads the data and sets full.
- Frame output: core_in_valid = hold_l_full & hold_r_full; core_in_data = {hold_l, hold_r}.
  - On core_in_valid & core_in_ready, both full flags clear.
  - A new sample cannot load in the same cycle as consumption (one-cycle bubble).
  - Latency: second sample accepted at edge N gives core_in_valid high after edge N.
- Backpressure: while core_in_ready=0, the frame holds stable and both adc readies stay 0. No data is dropped.
- Skew counter: increments each cycle exactly one hold is full; resets to 0 when both holds are empty or both are full.
  - When the count reaches SKEW_MAX, the lone held sample is discarded (its full flag clears).
  - In that cycle: desync pulses for 1 cycle and the counter resets.
- Output FIFO: write on core_out_valid & core_out_ready.
  - core_out_ready = (fifo_level < FIFO_DEPTH), combinational from the registered level.
  - Pointers wrap modulo FIFO_DEPTH.
- Head split: dac_x_data = head.x; dac_x_valid = !empty & !x_done.
  - A handshake on channel x sets x_done.
  - The head pops when both channels are consumed, including both handshakes in the same cycle or the second handshake arriving while the other x_done is set. Both done flags clear on pop.
- Simultaneous push and pop: fifo_level is unchanged and order is preserved.
- Push never occurs when full, because ready is low.

Optional Feature:
- Macro: DESYNC_CNT_EN.
- When defined: adds output desync_count (16 bits).
  - Increments on each desync pulse and saturates at 0xFFFF.
  - Reset value 0.
- When not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Frame pairing: L=0x123456, then R=0xABCDEF 3 cycles later, core_in_ready=1 -> core_in_data=0x123456ABCDEF valid for exactly 1 cycle; both adc readies return to 1 on the next cycle.
- Input backpressure: core_in_ready=0 with both samples held -> adc_l_ready=adc_r_ready=0; a second L (0x000001) stalls. Raise core_in_ready -> first frame accepted, then 0x000001 accepted into the left hold.
- Resync: only L pushed, SKEW_MAX=64 -> desync pulses at cycle 64 after acceptance; adc_l_ready=1; core_in_valid never asserts; desync_count=1 when DESYNC_CNT_EN is defined.
- Split with partial drain: 4 frames pushed with dac readies 0 -> fifo_level=4, core_out_ready=0. Then dac_l_ready=1 only -> one left sample accepted, dac_l_valid drops, level stays 4. Then dac_r_ready=1 -> pop, level=3, next head on both channels.
- Simultaneous push and pop: at level 3, both dac handshakes and a core_out push in the same cycle -> level stays 3; output order matches input order over 8 frames.
- Reset mid-operation: assert reset_reset_n=0 with L held and FIFO level 2 -> all outputs take their reset values immediately; after release, no stale samples appear.
